spi_2: RTL and testbench

SPI_2 -- requirements
Module: spi_2

---
 rtl/spi_2_pkg.sv | 24 ++
 rtl/spi_2_sync.sv | 54 +++++
 rtl/spi_2.sv | 152 +++++++++++++++
 tb/tb_spi_2.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/spi_2_pkg.sv
// spi_2_pkg: shared defaults and types for the spi_2 SPI slave.
//   DATA_W_DEF      - default word length in bits
//   SYNC_STAGES_DEF - default synchronizer depth for SCK/SIMO/CS
//   CNT_W_DEF       - bit-counter width for the default word length
//   state_e         - transfer state of the slave
//   cnt_width()     - bit-counter width for an arbitrary word length
package spi_2_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_W_DEF       = $clog2(DATA_W_DEF) + 1;

    // IDLE: no transfer armed (CS high, or CS was already low at reset release).
    // ACTIVE: a fresh CS falling edge has been seen and CS is still low.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    function automatic int cnt_width(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

endpackage

// File: rtl/spi_2_sync.sv
// spi_2_sync: multi-flop synchronizer with rise/fall edge detection.
//   clk, rst_n - system clock, asynchronous active-low reset
//   d          - asynchronous input pin
//   q          - synchronized level (after STAGES flops)
//   rise, fall - one-clk pulses on a synchronized 0->1 / 1->0 transition
// All flops reset to RESET_VAL. Edge outputs are held off until the chain
// has been refilled with real pin samples after reset, so a pin that is
// already at the opposite level at reset release does not report an edge.
module spi_2_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic [STAGES:0]   fill_q, fill_d;

    always_comb begin
        sync_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[STAGES-1];
        // fill_q tracks how far genuine samples have propagated into
        // sync_q/prev_q since reset; the top bit means prev_q is genuine.
        fill_d = {fill_q[STAGES-1:0], 1'b1};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before this clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
            fill_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            fill_q <= fill_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = fill_q[STAGES] &  q & ~prev_q;
    assign fall = fill_q[STAGES] & ~q &  prev_q;

endmodule

// File: rtl/spi_2.sv
// spi_2: SPI slave, mode 0 (CPOL=0, CPHA=0), MSB first, oversampled by clk.
//   clk, rst_n - system clock, asynchronous active-low reset
//   SCK        - serial clock from master (asynchronous to clk)
//   SIMO       - serial data from master
//   CS         - chip select, active-low
//   data_out   - word to send to the master; sampled at CS fall and at
//                each word completion only
//   SOMI       - serial data to master; 0 whenever no transfer is active
//   data_in    - last completely received word
//   tx_send    - one-clk pulse when a word completes
// SCK high and low times must each be at least SYNC_STAGES+2 clk periods.
module spi_2
    import spi_2_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SCK,
    input  logic              SIMO,
    input  logic              CS,
    input  logic [DATA_W-1:0] data_out,
    output logic              SOMI,
    output logic [DATA_W-1:0] data_in,
    output logic              tx_send
);

    localparam int               CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    // Synchronized pins and edges
    logic sck_s, sck_rise, sck_fall;
    logic cs_s, cs_rise, cs_fall;
    logic simo_s;

    spi_2_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (SCK),
        .q     (sck_s),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_2_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (CS),
        .q     (cs_s),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // SIMO needs only a level; its chain has the same depth as SCK's so the
    // data bit lines up with the synchronized rising edge that samples it.
    logic [SYNC_STAGES-1:0] simo_sync_q, simo_sync_d;

    always_comb begin
        simo_sync_d[0] = SIMO;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            simo_sync_d[i] = simo_sync_q[i-1];
        end
    end

    assign simo_s = simo_sync_q[SYNC_STAGES-1];

    // Transfer state and datapath
    state_e            state_q, state_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic              tx_send_q, tx_send_d;
    logic [DATA_W-1:0] rx_shift;

    assign rx_shift = {rx_q[DATA_W-2:0], simo_s};

    // NOTE: every signal written here is given a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        cnt_d     = cnt_q;
        data_in_d = data_in_q;
        tx_send_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Only a fresh CS falling edge arms a transfer; CS low at
                // reset release never produces cs_fall.
                if (cs_fall) begin
                    state_d = ST_ACTIVE;
                    tx_d    = data_out;
                    rx_d    = '0;
                    cnt_d   = '0;
                end
            end

            ST_ACTIVE: begin
                // Synced CS high takes priority over any SCK edge in the
                // same clk, so a completion coinciding with CS rise is lost.
                if (cs_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (sck_rise) begin
                    rx_d = rx_shift;
                    if (cnt_q == LAST_BIT) begin
                        data_in_d = rx_shift;
                        tx_send_d = 1'b1;
                        cnt_d     = '0;
                        tx_d      = data_out;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (sck_fall && (cnt_q != '0)) begin
                    // Counter 0 means either the leading edge of a word or
                    // the edge right after a reload: keep the MSB presented.
                    tx_d = {tx_q[DATA_W-2:0], 1'b0};
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            simo_sync_q <= '0;
            state_q     <= ST_IDLE;
            tx_q        <= '0;
            rx_q        <= '0;
            cnt_q       <= '0;
            data_in_q   <= '0;
            tx_send_q   <= 1'b0;
        end else begin
            simo_sync_q <= simo_sync_d;
            state_q     <= state_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            cnt_q       <= cnt_d;
            data_in_q   <= data_in_d;
            tx_send_q   <= tx_send_d;
        end
    end

    assign SOMI    = (state_q == ST_ACTIVE) & ~cs_s & tx_q[DATA_W-1];
    assign data_in = data_in_q;
    assign tx_send = tx_send_q;

endmodule

// File: tb/tb_spi_2.sv
// tb_spi_2: randomized, scoreboard-checked bench for the spi_2 SPI slave.
// The bench acts as an SPI master (100 MHz clk, 50 ns SCK half-period).
// A word-level model decides which words must complete and what the
// master must receive; completed words are queued and a monitor pops and
// compares them whenever the slave pulses tx_send.
module tb_spi_2;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         SCK = 1'b0;
    logic         SIMO = 1'b0;
    logic         CS = 1'b1;
    logic [W-1:0] data_out = '0;
    logic         SOMI;
    logic [W-1:0] data_in;
    logic         tx_send;

    spi_2 #(.DATA_W(W), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SCK      (SCK),
        .SIMO     (SIMO),
        .CS       (CS),
        .data_out (data_out),
        .SOMI     (SOMI),
        .data_in  (data_in),
        .tx_send  (tx_send)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [W-1:0] exp_q[$];      // words expected at tx_send, in order
    logic [W-1:0] last_word = '0; // value data_in must hold
    logic [W-1:0] model_tx = '0;  // word the slave must stream next
    bit           armed = 1'b0;   // fresh CS fall seen since reset
    int           words_pushed = 0;
    int           pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one pop per tx_send pulse, sampled on the falling clk edge.
    always @(negedge clk) begin
        if (rst_n && tx_send === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                check("unexpected_tx_send", 32'(tx_send), 32'd0);
            end else begin
                logic [W-1:0] w;
                w = exp_q.pop_front();
                check("data_in", 32'(data_in), 32'(w));
            end
        end
    end

    task automatic cs_low();
        CS       = 1'b0;
        armed    = 1'b1;
        model_tx = data_out;
        #100;
    endtask

    task automatic cs_high();
        CS = 1'b1;
        #100;
        check("data_in_hold", 32'(data_in), 32'(last_word));
        check("somi_cs_high", 32'(SOMI), 32'd0);
    endtask

    // Clock out nbits of mosi (MSB first). data_out switches to next_dout
    // just after the first rising edge, so it is the value seen at the
    // completion reload. The master samples SOMI on each SCK rise.
    task automatic send_word(input logic [W-1:0] mosi, input int nbits,
                             input logic [W-1:0] next_dout, input bit chk_somi);
        logic [W-1:0] somi_w;
        bit           completes;
        somi_w    = '0;
        completes = (nbits == W) && (CS == 1'b0) && armed;
        for (int i = 0; i < nbits; i++) begin
            SIMO = mosi[W-1-i];
            #50;
            if (i == W - 1 && completes) begin
                exp_q.push_back(mosi);
                words_pushed++;
                last_word = mosi;
            end
            SCK    = 1'b1;
            somi_w = {somi_w[W-2:0], SOMI};
            if (i == 0) data_out = next_dout;
            #50;
            SCK = 1'b0;
        end
        if (completes) begin
            if (chk_somi) check("somi_word", 32'(somi_w), 32'(model_tx));
            model_tx = next_dout;
        end
    endtask

    initial begin
        #3;
        check("rst_data_in", 32'(data_in), 32'd0);
        check("rst_tx_send", 32'(tx_send), 32'd0);
        check("rst_somi", 32'(SOMI), 32'd0);
        #20 rst_n = 1'b1;
        #100;

        // 16 SCK rising edges with CS high: nothing may happen.
        send_word(8'hA5, 8, 8'h00, 1'b0);
        send_word(8'h5A, 8, 8'h00, 1'b0);
        check("cs_high_data_in", 32'(data_in), 32'd0);
        check("cs_high_somi", 32'(SOMI), 32'd0);

        // Basic word: master sends A5, slave streams DD.
        data_out = 8'hDD;
        cs_low();
        send_word(8'hA5, 8, 8'hDD, 1'b1);
        cs_high();

        // Back-to-back words.
        data_out = 8'h81;
        cs_low();
        send_word(8'h3C, 8, 8'h7E, 1'b1);
        send_word(8'hC3, 8, 8'h7E, 1'b1);
        cs_high();

        // Abort after 4 bits, then a full word.
        cs_low();
        send_word(8'hF0, 4, data_out, 1'b0);
        cs_high();
        cs_low();
        send_word(8'h55, 8, data_out, 1'b1);
        cs_high();

        // data_out changed mid-word is ignored.
        data_out = 8'hDD;
        cs_low();
        send_word(8'h12, 8, 8'h00, 1'b1);
        cs_high();

        // Reset after 5 bits; CS stays low through release and must be
        // ignored until re-cycled.
        data_out = 8'h5A;
        cs_low();
        send_word(8'hFF, 5, data_out, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data_in", 32'(data_in), 32'd0);
        check("mid_rst_tx_send", 32'(tx_send), 32'd0);
        check("mid_rst_somi", 32'(SOMI), 32'd0);
        armed     = 1'b0;
        last_word = '0;
        #20 rst_n = 1'b1;
        #100;
        send_word(8'h3C, 8, data_out, 1'b0);
        check("unarmed_somi", 32'(SOMI), 32'd0);
        check("unarmed_data_in", 32'(data_in), 32'd0);
        cs_high();
        data_out = 8'h66;
        cs_low();
        send_word(8'h99, 8, data_out, 1'b1);
        cs_high();

        // Randomized transactions: 1-3 words per CS window, occasional abort.
        for (int t = 0; t < 20; t++) begin
            int nwords;
            data_out = W'($urandom);
            nwords   = int'($urandom_range(1, 3));
            cs_low();
            for (int k = 0; k < nwords; k++) begin
                if ($urandom_range(0, 4) == 0) begin
                    send_word(W'($urandom), int'($urandom_range(1, W - 1)), data_out, 1'b0);
                    break;
                end
                send_word(W'($urandom), W, W'($urandom), 1'b1);
            end
            cs_high();
        end

        #200;
        check("pending_words", 32'(exp_q.size()), 32'd0);
        check("pulse_count", 32'(pulses), 32'(words_pushed));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
